rc4_crack_sequencer: RTL and testbench

Top-level controller for brute-force RC4 key search.
- For each candidate key it runs three phases in order: S-memory init, key scheduling (KSA), then decrypt/compute.
- It issues one-cycle start strobes to each phase FSM and waits for that phase's completion strobe.
- It arbitrates the single shared S-memory port, so only the active phase can read or write it.
- It checks the decrypt verdict, then either steps to the next key or stops with found or failed.

---
 rtl/rc4_crack_sequencer_pkg.sv | 42 ++++
 rtl/rc4_crack_sequencer_s_mem_arbiter.sv | 55 +++++
 rtl/rc4_crack_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_rc4_crack_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_crack_sequencer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rc4_pkg                                                               |
// | Shared types for the RC4 key-search sequencer and its S-mem arbiter.  |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
package rc4_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_GO   = 4'd1,
        ST_INIT_WAIT = 4'd2,
        ST_KSA_GO    = 4'd3,
        ST_KSA_WAIT  = 4'd4,
        ST_COMP_GO   = 4'd5,
        ST_COMP_WAIT = 4'd6,
        ST_NEXT_KEY  = 4'd7,
        ST_FOUND     = 4'd8,
        ST_FAIL      = 4'd9
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_INIT = 2'd1,
        OWN_KSA  = 2'd2,
        OWN_COMP = 2'd3
    } owner_e;

    function automatic owner_e owner_of(input state_e s);
        case (s)
            ST_INIT_GO, ST_INIT_WAIT: owner_of = OWN_INIT;
            ST_KSA_GO,  ST_KSA_WAIT:  owner_of = OWN_KSA;
            ST_COMP_GO, ST_COMP_WAIT: owner_of = OWN_COMP;
            default:                  owner_of = OWN_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/rc4_crack_sequencer_s_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | s_mem_arbiter                                                         |
// | Combinational 3:1 S-memory port mux selected by the current owner.    |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module s_mem_arbiter
    import rc4_pkg::*;
(
    input  owner_e                owner_i,
    input  logic [S_ADDR_W-1:0]   init_addr_i,
    input  logic [S_DATA_W-1:0]   init_data_i,
    input  logic                  init_wren_i,
    input  logic [S_ADDR_W-1:0]   ksa_addr_i,
    input  logic [S_DATA_W-1:0]   ksa_data_i,
    input  logic                  ksa_wren_i,
    input  logic [S_ADDR_W-1:0]   comp_addr_i,
    input  logic [S_DATA_W-1:0]   comp_data_i,
    input  logic                  comp_wren_i,
    output logic [S_ADDR_W-1:0]   s_addr_o,
    output logic [S_DATA_W-1:0]   s_data_o,
    output logic                  s_wren_o
);

    // Only the owning requester is ever selected, so stray writes are dropped.
    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_wren_o = 1'b0;
        unique case (owner_i)
            OWN_INIT: begin
                s_addr_o = init_addr_i;
                s_data_o = init_data_i;
                s_wren_o = init_wren_i;
            end
            OWN_KSA: begin
                s_addr_o = ksa_addr_i;
                s_data_o = ksa_data_i;
                s_wren_o = ksa_wren_i;
            end
            OWN_COMP: begin
                s_addr_o = comp_addr_i;
                s_data_o = comp_data_i;
                s_wren_o = comp_wren_i;
            end
            OWN_NONE: begin
                s_addr_o = '0;
                s_data_o = '0;
                s_wren_o = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rc4_crack_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | rc4_crack_sequencer                                                   |
// | Brute-force RC4 key search controller: init -> KSA -> compute per key.|
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module rc4_crack_sequencer
    import rc4_pkg::*;
#(
    parameter int                KEY_W     = 24,
    parameter logic [KEY_W-1:0]  KEY_START = '0,
    parameter logic [KEY_W-1:0]  KEY_LAST  = {KEY_W{1'b1}},
    parameter int                TMO_W     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 init_start,
    input  logic                 init_done,
    output logic                 ksa_start,
    input  logic                 ksa_done,
    output logic                 comp_start,
    input  logic                 comp_done,
    input  logic                 msg_ok,
    input  logic [S_ADDR_W-1:0]  init_addr,
    input  logic [S_DATA_W-1:0]  init_data,
    input  logic                 init_wren,
    input  logic [S_ADDR_W-1:0]  ksa_addr,
    input  logic [S_DATA_W-1:0]  ksa_data,
    input  logic                 ksa_wren,
    input  logic [S_ADDR_W-1:0]  comp_addr,
    input  logic [S_DATA_W-1:0]  comp_data,
    input  logic                 comp_wren,
    output logic [S_ADDR_W-1:0]  s_addr,
    output logic [S_DATA_W-1:0]  s_data,
    output logic                 s_wren,
    output logic [KEY_W-1:0]     key,
    output logic                 busy,
    output logic                 found,
    output logic                 failed,
    output logic                 timeout
);

    // Last counter value before the limit; the next idle wait cycle times out.
    localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    state_e            state_q, state_d;
    owner_e            owner_q;
    logic [KEY_W-1:0]  key_q, key_d;
    logic [TMO_W-1:0]  wdog_q, wdog_d;
    logic              found_q, found_d;
    logic              failed_q, failed_d;
    logic              timeout_q, timeout_d;
    logic              w_waiting;
    logic              w_done;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_NONE;
            key_q     <= KEY_START;
            wdog_q    <= '0;
            found_q   <= 1'b0;
            failed_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            assert (KEY_LAST >= KEY_START)
                else $error("rc4_crack_sequencer: KEY_LAST below KEY_START");
            state_q   <= state_d;
            owner_q   <= owner_of(state_d);
            key_q     <= key_d;
            wdog_q    <= wdog_d;
            found_q   <= found_d;
            failed_q  <= failed_d;
            timeout_q <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        wdog_d     = wdog_q;
        found_d    = found_q;
        failed_d   = failed_q;
        timeout_d  = timeout_q;
        init_start = 1'b0;
        ksa_start  = 1'b0;
        comp_start = 1'b0;
        w_waiting  = 1'b0;
        w_done     = 1'b0;

        case (state_q)
            ST_IDLE, ST_FOUND, ST_FAIL: begin
                if (start) begin
                    key_d     = KEY_START;
                    found_d   = 1'b0;
                    failed_d  = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = ST_INIT_GO;
                end
            end
            ST_INIT_GO: begin
                init_start = 1'b1;
                wdog_d     = '0;
                state_d    = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                w_waiting = 1'b1;
                w_done    = init_done;
                if (init_done) state_d = ST_KSA_GO;
            end
            ST_KSA_GO: begin
                ksa_start = 1'b1;
                wdog_d    = '0;
                state_d   = ST_KSA_WAIT;
            end
            ST_KSA_WAIT: begin
                w_waiting = 1'b1;
                w_done    = ksa_done;
                if (ksa_done) state_d = ST_COMP_GO;
            end
            ST_COMP_GO: begin
                comp_start = 1'b1;
                wdog_d     = '0;
                state_d    = ST_COMP_WAIT;
            end
            ST_COMP_WAIT: begin
                w_waiting = 1'b1;
                w_done    = comp_done;
                if (comp_done) begin
                    if (msg_ok) begin
                        found_d = 1'b1;
                        state_d = ST_FOUND;
                    end else if (key_q == KEY_LAST) begin
                        failed_d = 1'b1;
                        state_d  = ST_FAIL;
                    end else begin
                        state_d = ST_NEXT_KEY;
                    end
                end
            end
            ST_NEXT_KEY: begin
                key_d   = key_q + 1'b1;
                state_d = ST_INIT_GO;
            end
            default: state_d = ST_IDLE;
        endcase

        // A done strobe on the limit cycle wins because w_done blocks this path.
        if (w_waiting && !w_done) begin
            if (wdog_q == WDOG_LAST) begin
                failed_d  = 1'b1;
                timeout_d = 1'b1;
                state_d   = ST_FAIL;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end
    end

    assign busy    = !(state_q == ST_IDLE || state_q == ST_FOUND || state_q == ST_FAIL);
    assign key     = key_q;
    assign found   = found_q;
    assign failed  = failed_q;
    assign timeout = timeout_q;

    s_mem_arbiter u_arb (
        .owner_i     (owner_q),
        .init_addr_i (init_addr),
        .init_data_i (init_data),
        .init_wren_i (init_wren),
        .ksa_addr_i  (ksa_addr),
        .ksa_data_i  (ksa_data),
        .ksa_wren_i  (ksa_wren),
        .comp_addr_i (comp_addr),
        .comp_data_i (comp_data),
        .comp_wren_i (comp_wren),
        .s_addr_o    (s_addr),
        .s_data_o    (s_data),
        .s_wren_o    (s_wren)
    );

endmodule
`default_nettype wire

// File: tb/tb_rc4_crack_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_rc4_crack_sequencer                                                |
// | Directed self-checking bench: instance A (full range), B (keys 5..6). |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_rc4_crack_sequencer;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] init_addr, init_data, ksa_addr, ksa_data, comp_addr, comp_data;
    logic       init_wren, ksa_wren, comp_wren;

    // Instance A stimulus / responses
    logic        start_a, init_start_a, ksa_start_a, comp_start_a;
    logic        init_done_a, ksa_done_a, comp_done_a, msg_ok_a;
    logic [7:0]  s_addr_a, s_data_a;
    logic        s_wren_a, busy_a, found_a, failed_a, timeout_a;
    logic [23:0] key_a;
    logic        en_init, en_ksa, en_comp, man_ksa_done, man_comp_done, man_msg_ok;
    logic [23:0] ok_key;
    int          ic, kc, cc;

    // Instance B stimulus / responses
    logic        start_b, init_start_b, ksa_start_b, comp_start_b, done_b;
    logic [7:0]  s_addr_b, s_data_b;
    logic        s_wren_b, busy_b, found_b, failed_b, timeout_b;
    logic [23:0] key_b;
    int          pc_b;

    logic clr;
    int   n_init_a, n_ksa_a, n_comp_a, n_init_b;

    rc4_crack_sequencer #(.KEY_W(24), .KEY_START(24'd0), .KEY_LAST(24'hFFFFFF), .TMO_W(4)) u_dut_a (
        .clk(clk), .rst(rst_n), .start(start_a),
        .init_start(init_start_a), .init_done(init_done_a),
        .ksa_start(ksa_start_a), .ksa_done(ksa_done_a),
        .comp_start(comp_start_a), .comp_done(comp_done_a), .msg_ok(msg_ok_a),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
        .comp_addr(comp_addr), .comp_data(comp_data), .comp_wren(comp_wren),
        .s_addr(s_addr_a), .s_data(s_data_a), .s_wren(s_wren_a),
        .key(key_a), .busy(busy_a), .found(found_a), .failed(failed_a), .timeout(timeout_a)
    );

    rc4_crack_sequencer #(.KEY_W(24), .KEY_START(24'd5), .KEY_LAST(24'd6), .TMO_W(4)) u_dut_b (
        .clk(clk), .rst(rst_n), .start(start_b),
        .init_start(init_start_b), .init_done(done_b),
        .ksa_start(ksa_start_b), .ksa_done(done_b),
        .comp_start(comp_start_b), .comp_done(done_b), .msg_ok(1'b0),
        .init_addr(init_addr), .init_data(init_data), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_data(ksa_data), .ksa_wren(ksa_wren),
        .comp_addr(comp_addr), .comp_data(comp_data), .comp_wren(comp_wren),
        .s_addr(s_addr_b), .s_data(s_data_b), .s_wren(s_wren_b),
        .key(key_b), .busy(busy_b), .found(found_b), .failed(failed_b), .timeout(timeout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase models: done returns a fixed number of cycles after each start strobe.
    always @(posedge clk) begin
        if (!rst_n) begin
            ic <= 0; kc <= 0; cc <= 0; pc_b <= 0;
        end else begin
            ic   <= init_start_a ? 5 : (ic > 0 ? ic - 1 : 0);
            kc   <= ksa_start_a  ? 5 : (kc > 0 ? kc - 1 : 0);
            cc   <= comp_start_a ? 5 : (cc > 0 ? cc - 1 : 0);
            pc_b <= (init_start_b || ksa_start_b || comp_start_b) ? 2 : (pc_b > 0 ? pc_b - 1 : 0);
        end
    end

    assign init_done_a = en_init && ic == 1;
    assign ksa_done_a  = man_ksa_done  | (en_ksa  && kc == 1);
    assign comp_done_a = man_comp_done | (en_comp && cc == 1);
    assign msg_ok_a    = man_msg_ok | (key_a == ok_key);
    assign done_b      = (pc_b == 1);

    always @(posedge clk) begin
        if (clr) begin
            n_init_a <= 0; n_ksa_a <= 0; n_comp_a <= 0; n_init_b <= 0;
        end else begin
            if (init_start_a) n_init_a <= n_init_a + 1;
            if (ksa_start_a)  n_ksa_a  <= n_ksa_a + 1;
            if (comp_start_a) n_comp_a <= n_comp_a + 1;
            if (init_start_b) n_init_b <= n_init_b + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            end
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; clr = 1'b0;
        en_init = 1'b1; en_ksa = 1'b1; en_comp = 1'b1;
        man_ksa_done = 1'b0; man_comp_done = 1'b0; man_msg_ok = 1'b0;
        ok_key = 24'd0;
        init_addr = 8'h11; init_data = 8'h31; init_wren = 1'b1;
        ksa_addr  = 8'h22; ksa_data  = 8'h42; ksa_wren  = 1'b0;
        comp_addr = 8'h33; comp_data = 8'h53; comp_wren = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy", busy_a, 1'b0);
        check("rst_key_a", key_a, 24'd0);
        check("rst_key_b", key_b, 24'd5);
        check("rst_flags", {found_a, failed_a, timeout_a}, 3'b000);
        check("rst_starts", {init_start_a, ksa_start_a, comp_start_a}, 3'b000);
        check("rst_s_port", {s_addr_a, s_data_a, s_wren_a}, 17'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_s_port", {s_addr_a, s_wren_a}, 9'h0);

        // 1: single pass, key 0 matches
        clear_counts();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t1_init_start_lat", init_start_a, 1'b1);
        check("t1_busy", busy_a, 1'b1);
        check("t1_init_owner", {s_addr_a, s_data_a, s_wren_a}, {8'h11, 8'h31, 1'b1});
        for (int n = 0; n < 300 && found_a !== 1'b1; n++) @(negedge clk);
        check("t1_found", found_a, 1'b1);
        check("t1_busy_end", busy_a, 1'b0);
        check("t1_key", key_a, 24'd0);
        check("t1_pulses", {n_init_a[7:0], n_ksa_a[7:0], n_comp_a[7:0]}, 24'h010101);
        check("t1_found_s_port", {s_addr_a, s_wren_a}, 9'h0);

        // 2: keys 0..2 rejected, key 3 accepted
        clear_counts();
        ok_key = 24'd3;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 400 && found_a !== 1'b1; n++) @(negedge clk);
        check("t2_found", {found_a, failed_a}, 2'b10);
        check("t2_key", key_a, 24'd3);
        check("t2_init_pulses", n_init_a, 4);

        // 3: range 5..6 exhausted on instance B
        clear_counts();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        check("t3_init_start", init_start_b, 1'b1);
        for (int n = 0; n < 300 && failed_b !== 1'b1; n++) @(negedge clk);
        check("t3_flags", {failed_b, timeout_b, found_b, busy_b}, 4'b1000);
        check("t3_key", key_b, 24'd6);
        repeat (10) @(negedge clk);
        check("t3_init_pulses", n_init_b, 2);

        // 4: arbiter isolation during KSA_WAIT
        ok_key = 24'd0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 100 && ksa_start_a !== 1'b1; n++) @(negedge clk);
        check("t4_ksa_start_seen", ksa_start_a, 1'b1);
        @(negedge clk);
        check("t4_ksa_owner", {s_addr_a, s_data_a, s_wren_a}, {8'h22, 8'h42, 1'b0});
        ksa_wren = 1'b1;
        #1;
        check("t4_ksa_wren", s_wren_a, 1'b1);
        ksa_wren = 1'b0;
        for (int n = 0; n < 100 && found_a !== 1'b1; n++) @(negedge clk);
        check("t4_found", found_a, 1'b1);

        // 5: watchdog expiry in KSA_WAIT, then done on the limit cycle
        en_ksa = 1'b0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 100 && ksa_start_a !== 1'b1; n++) @(negedge clk);
        repeat (15) @(negedge clk);
        check("t5_pre_limit", {busy_a, failed_a}, 2'b10);
        @(negedge clk);
        check("t5_timeout", {failed_a, timeout_a, found_a, busy_a}, 4'b1100);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t5_restart_clears", {failed_a, timeout_a}, 2'b00);
        for (int n = 0; n < 100 && ksa_start_a !== 1'b1; n++) @(negedge clk);
        repeat (15) @(negedge clk);
        man_ksa_done = 1'b1;
        @(negedge clk);
        man_ksa_done = 1'b0;
        check("t5_done_wins", {comp_start_a, failed_a, timeout_a, busy_a}, 4'b1001);
        en_ksa = 1'b1;
        for (int n = 0; n < 100 && found_a !== 1'b1; n++) @(negedge clk);
        check("t5_found", found_a, 1'b1);

        // 6: reset mid-search, stray done in IDLE, start while busy
        ok_key = 24'd99;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 300 && !(comp_start_a === 1'b1 && key_a === 24'd2); n++) @(negedge clk);
        check("t6_key2_comp", {comp_start_a, key_a}, {1'b1, 24'd2});
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_reset_abort", {busy_a, key_a, s_wren_a, s_addr_a}, 33'h0);
        rst_n = 1'b1;
        man_comp_done = 1'b1;
        man_msg_ok = 1'b1;
        @(negedge clk);
        man_comp_done = 1'b0;
        man_msg_ok = 1'b0;
        @(negedge clk);
        check("t6_stray_done", {found_a, busy_a, init_start_a}, 3'b000);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int n = 0; n < 100 && !(init_start_a === 1'b1 && key_a === 24'd1); n++) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        check("t6_start_ignored", {key_a, init_start_a, busy_a}, {24'd1, 1'b0, 1'b1});

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
